// File: rtl/cpu_run_sequencer_pkg.sv
// run_seq_pkg: shared state, program-ID types and constants for the run sequencer
package run_seq_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, ABORT} state_t;
  typedef logic [1:0] prog_t;
  localparam prog_t PROG_DIV = 2'd1;
  localparam prog_t PROG_AVG = 2'd2;
  localparam prog_t PROG_COV = 2'd3;
endpackage

// File: rtl/cpu_run_sequencer_if.sv
// cpu_run_sequencer_if: host request, CPU launch handshake and completion record signals
interface cpu_run_sequencer_if #(parameter int CNT_W = 16);
  import run_seq_pkg::*;
  logic             ReqValid;
  prog_t            ReqProg;
  logic             ReqReady;
  logic             CpuStart;
  prog_t            CpuProg;
  logic             CpuAck;
  logic             CpuAbort;
  logic             DoneValid;
  prog_t            DoneProg;
  logic [CNT_W-1:0] DoneCycles;
  logic             DoneTimeout;
  logic             Busy;
  modport slave (
    input  ReqValid, ReqProg, CpuAck,
    output ReqReady, CpuStart, CpuProg, CpuAbort, DoneValid, DoneProg, DoneCycles, DoneTimeout, Busy
  );
  modport master (
    output ReqValid, ReqProg, CpuAck,
    input  ReqReady, CpuStart, CpuProg, CpuAbort, DoneValid, DoneProg, DoneCycles, DoneTimeout, Busy
  );
endinterface

// File: rtl/cpu_run_sequencer_fifo.sv
// run_seq_fifo: DEPTH x 2-bit request FIFO with full/empty/count and async reset
module run_seq_fifo import run_seq_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  prog_t                    data_i,
  input  logic                     pop_i,
  output prog_t                    data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  prog_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= do_push ? wr_q + 1'b1 : wr_q;
      rd_q  <= do_pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
  // Storage needs no reset: the pointers define which entries are live
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
  assign data_o  = mem_q[rd_q];
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/cpu_run_sequencer.sv
// cpu_run_sequencer: queues program runs and sequences them onto the CPU Start/Ack handshake
module cpu_run_sequencer import run_seq_pkg::*; #(
  parameter int DEPTH        = 4,
  parameter int START_CYCLES = 2,
  parameter int CNT_W        = 16,
  parameter int TIMEOUT      = 4096
) (
  input logic Clk,
  input logic Reset,
  cpu_run_sequencer_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST_START = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO        = CNT_W'(TIMEOUT);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, dcyc_q, dcyc_d;
  prog_t prog_q, prog_d, dprog_q, dprog_d, head;
  logic armed_q, armed_d, start_q, start_d, abort_q, abort_d;
  logic dv_q, dv_d, dto_q, dto_d, busy_q, busy_d;
  logic pop, full, empty;
  logic [$clog2(DEPTH):0] fifo_count;
  run_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (Clk),
    .rst    (Reset),
    .push_i (bus.ReqValid),
    .data_i (bus.ReqProg),
    .pop_i  (pop),
    .data_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(fifo_count)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    prog_d  = prog_q;
    dprog_d = dprog_q;
    dcyc_d  = dcyc_q;
    dto_d   = dto_q;
    dv_d    = 1'b0;
    abort_d = 1'b0;
    start_d = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        prog_d  = head;
        cnt_d   = '0;
        armed_d = 1'b0;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        start_d = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == LAST_START ? RUN : LAUNCH;
      end
      RUN: begin
        cnt_d   = cnt_q + 1'b1;
        armed_d = armed_q || !bus.CpuAck;
        // A qualified Ack takes priority over the watchdog on the same cycle
        if (armed_q && bus.CpuAck) begin
          dv_d    = 1'b1;
          dto_d   = 1'b0;
          dprog_d = prog_q;
          dcyc_d  = cnt_q;
          state_d = IDLE;
        end else if (cnt_q == TMO) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        abort_d = 1'b1;
        dv_d    = 1'b1;
        dto_d   = 1'b1;
        dprog_d = prog_q;
        dcyc_d  = TMO;
        state_d = IDLE;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      prog_q  <= '0;
      dprog_q <= '0;
      dcyc_q  <= '0;
      dto_q   <= 1'b0;
      dv_q    <= 1'b0;
      abort_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      prog_q  <= prog_d;
      dprog_q <= dprog_d;
      dcyc_q  <= dcyc_d;
      dto_q   <= dto_d;
      dv_q    <= dv_d;
      abort_q <= abort_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end
  assign bus.ReqReady    = !full && !Reset;
  assign bus.CpuStart    = start_q;
  assign bus.CpuProg     = prog_q;
  assign bus.CpuAbort    = abort_q;
  assign bus.DoneValid   = dv_q;
  assign bus.DoneProg    = dprog_q;
  assign bus.DoneCycles  = dcyc_q;
  assign bus.DoneTimeout = dto_q;
  assign bus.Busy        = busy_q;
endmodule

// File: tb/tb_cpu_run_sequencer.sv
// tb_cpu_run_sequencer: vector table plus scoreboard checks of the run sequencer
module tb_cpu_run_sequencer;
  import run_seq_pkg::*;
  localparam int CNT_W = 16;
  localparam int TMO   = 32;
  localparam int START = 2;
  typedef struct {
    prog_t            prog;
    logic [CNT_W-1:0] cyc;
    logic             to;
  } exp_t;
  typedef struct {
    prog_t            prog;
    int               stale_hi;
    int               ack_at;
    logic [CNT_W-1:0] cyc;
    logic             to;
  } vec_t;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done = -100;
  logic prev_dv = 1'b0;
  logic [CNT_W-1:0] prev_cyc = '0;
  exp_t sb[$];
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  cpu_run_sequencer_if #(.CNT_W(CNT_W)) bus();
  cpu_run_sequencer #(
    .DEPTH(4), .START_CYCLES(START), .CNT_W(CNT_W), .TIMEOUT(TMO)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  // Completion monitor: every DoneValid must match the oldest expected record
  always @(negedge Clk) begin
    if (Reset) prev_dv <= 1'b0;
    else begin
      if (prev_dv) begin
        chk("dv_pulse", bus.DoneValid, 0);
        chk("done_hold", bus.DoneCycles, prev_cyc);
      end
      if (bus.DoneValid) begin
        chk("done_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          chk("done_prog", bus.DoneProg, sb[0].prog);
          chk("done_cycles", bus.DoneCycles, sb[0].cyc);
          chk("done_timeout", bus.DoneTimeout, sb[0].to);
          chk("abort_pulse", bus.CpuAbort, sb[0].to);
          sb.delete(0);
        end
        last_done <= cyc;
      end else if (bus.CpuAbort) chk("abort_without_done", bus.CpuAbort, 0);
      prev_dv  <= bus.DoneValid;
      prev_cyc <= bus.DoneCycles;
    end
  end
  task automatic push(input prog_t p);
    int n = 0;
    bus.ReqValid = 1'b1;
    bus.ReqProg  = p;
    while (!bus.ReqReady && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("req_accept", bus.ReqReady, 1);
    @(negedge Clk);
    bus.ReqValid = 1'b0;
  endtask
  // Cycle j = j-th cycle counted from the first CpuStart-high cycle
  task automatic run(input prog_t p, input int stale_hi, input int ack_at, input int exp_lat);
    int lat = 0;
    int nst = 0;
    int j = 1;
    while (!bus.CpuStart && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    if (exp_lat >= 0) chk("start_latency", lat, exp_lat);
    chk("cpu_prog", bus.CpuProg, p);
    while (!bus.DoneValid && j < 200) begin
      nst += int'(bus.CpuStart);
      bus.CpuAck = (j <= stale_hi) || (ack_at > 0 && j >= ack_at);
      @(negedge Clk);
      j++;
    end
    chk("done_seen", bus.DoneValid, 1);
    chk("start_width", nst, START);
    bus.CpuAck = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t vt[6];
    exp_t e;
    int n;
    vt[0] = '{PROG_DIV, 0, 12, 12, 1'b0};
    vt[1] = '{PROG_AVG, 5, 8, 8, 1'b0};
    vt[2] = '{PROG_COV, 0, 0, TMO, 1'b1};
    vt[3] = '{2'd0, 0, 3, 3, 1'b0};
    vt[4] = '{PROG_DIV, 0, 2, TMO, 1'b1};
    vt[5] = '{PROG_AVG, 0, TMO, TMO, 1'b0};
    bus.ReqValid = 1'b0;
    bus.ReqProg  = '0;
    bus.CpuAck   = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_ready", bus.ReqReady, 0);
    chk("rst_start", bus.CpuStart, 0);
    chk("rst_abort", bus.CpuAbort, 0);
    chk("rst_dv", bus.DoneValid, 0);
    chk("rst_dto", bus.DoneTimeout, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_cpuprog", bus.CpuProg, 0);
    chk("rst_dprog", bus.DoneProg, 0);
    chk("rst_dcyc", bus.DoneCycles, 0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("idle_ready", bus.ReqReady, 1);
    chk("idle_busy", bus.Busy, 0);
    for (int i = 0; i < 6; i++) begin
      push(vt[i].prog);
      sb.push_back('{vt[i].prog, vt[i].cyc, vt[i].to});
      run(vt[i].prog, vt[i].stale_hi, vt[i].ack_at, 2);
    end
    // Backpressure: first job times out while four more fill the FIFO
    for (int i = 0; i < 6; i++) begin
      bus.ReqValid = 1'b1;
      bus.ReqProg  = prog_t'(i + 1);
      chk("bp_ready", bus.ReqReady, i < 5);
      if (i == 0) begin
        e = '{prog_t'(1), CNT_W'(TMO), 1'b1};
        sb.push_back(e);
      end else if (i < 5) begin
        e = '{prog_t'(i + 1), CNT_W'(5), 1'b0};
        sb.push_back(e);
      end
      @(negedge Clk);
    end
    n = 0;
    while (!bus.ReqReady && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("bp_release_after_done", cyc - last_done, 1);
    e = '{prog_t'(6), CNT_W'(5), 1'b0};
    sb.push_back(e);
    @(negedge Clk);
    bus.ReqValid = 1'b0;
    run(prog_t'(2), 0, 5, -1);
    for (int i = 3; i <= 6; i++) run(prog_t'(i), 0, 5, 2);
    // Reset during RUN with two jobs queued: nothing may complete or launch afterwards
    push(PROG_DIV);
    push(PROG_AVG);
    push(PROG_COV);
    repeat (8) @(negedge Clk);
    chk("pre_reset_busy", bus.Busy, 1);
    Reset = 1'b1;
    #1;
    chk("mid_rst_busy", bus.Busy, 0);
    chk("mid_rst_start", bus.CpuStart, 0);
    chk("mid_rst_ready", bus.ReqReady, 0);
    chk("mid_rst_cpuprog", bus.CpuProg, 0);
    @(negedge Clk);
    Reset = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      n += int'(bus.DoneValid || bus.CpuStart || bus.Busy);
    end
    chk("post_reset_quiet", n, 0);
    push(PROG_COV);
    sb.push_back('{PROG_COV, CNT_W'(4), 1'b0});
    run(PROG_COV, 0, 4, 2);
    // Back-to-back 1,2,3 with two-cycle DoneValid-to-CpuStart gaps
    push(PROG_DIV);
    push(PROG_AVG);
    push(PROG_COV);
    sb.push_back('{PROG_DIV, CNT_W'(5), 1'b0});
    sb.push_back('{PROG_AVG, CNT_W'(5), 1'b0});
    sb.push_back('{PROG_COV, CNT_W'(5), 1'b0});
    run(PROG_DIV, 0, 5, 0);
    run(PROG_AVG, 0, 5, 2);
    run(PROG_COV, 0, 5, 2);
    repeat (3) @(negedge Clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
